// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-lane writes, rdata registered and visible the cycle after the access edge.
// WAIT_CYCLES>0 adds an IDLE/BUSY FSM that raises stallreq_mem for exactly WAIT_CYCLES cycles per access.
module data_sram_resp #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_mem,
  output logic        addr_err
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit         USE_FSM  = (WAIT_CYCLES != 0);
  localparam logic [3:0] CNT_INIT = USE_FSM ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  lat_wen_q, lat_wen_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        addr_err_q, addr_err_d;

  logic                  acc_vld;
  logic [3:0]            acc_wen;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_oor;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  mem_we;
  logic                  unused_addr_lsb;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_wen_q   <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_wen_q   <= lat_wen_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // The request is captured on entry to BUSY; the CPU's held inputs are not looked at again.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_wen_d   = lat_wen_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    if (USE_FSM) begin
      case (state_q)
        IDLE: begin
          if (data_sram_en) begin
            state_d     = BUSY;
            cnt_d       = CNT_INIT;
            lat_wen_d   = data_sram_wen;
            lat_addr_d  = data_sram_addr;
            lat_wdata_d = data_sram_wdata;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_vld      = data_sram_en;
    acc_wen      = data_sram_wen;
    acc_addr     = data_sram_addr;
    acc_wdata    = data_sram_wdata;
    stallreq_mem = 1'b0;
    if (USE_FSM) begin
      acc_vld      = (state_q == BUSY) && (cnt_q == 4'd0);
      acc_wen      = lat_wen_q;
      acc_addr     = lat_addr_q;
      acc_wdata    = lat_wdata_q;
      stallreq_mem = (state_q == IDLE) ? data_sram_en : (cnt_q != 4'd0);
    end
  end

  assign acc_oor         = |acc_addr[31:ADDR_WIDTH+2];
  assign acc_idx         = acc_addr[ADDR_WIDTH+1:2];
  assign unused_addr_lsb = ^acc_addr[1:0];
  assign mem_we          = acc_vld && (acc_wen != 4'b0000) && !acc_oor;

  always_comb begin
    rdata_d    = rdata_q;
    addr_err_d = acc_vld && acc_oor;
    if (acc_vld && (acc_wen == 4'b0000)) begin
      rdata_d = acc_oor ? ERR_DATA : mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: a zero-wait instance and a 3-wait instance driven side by side,
// checked against a word-array model of the RAM, rdata register and error pulse.
module tb_data_sram_resp;

  localparam int          AW    = 10;
  localparam int          WAITN = 3;
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, en3 = 1'b0;
  logic [3:0]  wen0 = '0, wen3 = '0;
  logic [31:0] addr0 = '0, addr3 = '0;
  logic [31:0] wdata0 = '0, wdata3 = '0;
  logic [31:0] rdata0, rdata3;
  logic        stall0, stall3, err0, err3;

  data_sram_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0), .ERR_DATA(ERRD)) dut0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
    .stallreq_mem(stall0), .addr_err(err0)
  );

  data_sram_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITN), .ERR_DATA(ERRD)) dut3 (
    .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
    .stallreq_mem(stall3), .addr_err(err3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per instance: first 16 words of RAM, last rdata, last error flag.
  logic [31:0] rm [2][16];
  logic [31:0] rr [2];
  logic        re [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] wen);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (wen[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  task automatic model(input int d, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit oor;
    int w;
    oor   = (addr >= (32'd1 << (AW + 2)));
    w     = int'(addr >> 2);
    re[d] = en && oor;
    if (en) begin
      if (wen == 4'b0000)  rr[d] = oor ? ERRD : rm[d][w];
      else if (!oor)       rm[d][w] = (rm[d][w] & ~lane_mask(wen)) | (wdata & lane_mask(wen));
    end
  endtask

  // One cycle on the zero-wait instance; called at posedge+1, returns at the next posedge+1.
  task automatic acc0(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input string tag);
    en0 = en; wen0 = wen; addr0 = addr; wdata0 = wdata;
    @(negedge clk);
    check({tag, "_stall"}, 32'(stall0), 32'd0);
    @(posedge clk); #1;
    model(0, en, wen, addr, wdata);
    check({tag, "_rdata"}, rdata0, rr[0]);
    check({tag, "_err"}, 32'(err0), 32'(re[0]));
    en0 = 1'b0;
  endtask

  // One full access on the wait-state instance, including the idle cycle that follows it.
  task automatic acc3(input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input string tag);
    int n;
    en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
    @(negedge clk);
    check({tag, "_stall_first"}, 32'(stall3), 32'd1);
    n = 1;
    @(posedge clk); #1;
    wen3 = 4'($urandom); addr3 = $urandom; wdata3 = $urandom;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!stall3) break;
      n++;
      check({tag, "_busy_err"}, 32'(err3), 32'd0);
    end
    check({tag, "_nstall"}, 32'(n), 32'(WAITN));
    @(posedge clk); #1;
    en3 = 1'b0;
    model(1, 1'b1, wen, addr, wdata);
    check({tag, "_rdata"}, rdata3, rr[1]);
    check({tag, "_err"}, 32'(err3), 32'(re[1]));
    @(negedge clk);
    check({tag, "_idle_stall"}, 32'(stall3), 32'd0);
    @(posedge clk); #1;
    check({tag, "_err_pulse"}, 32'(err3), 32'd0);
    check({tag, "_hold"}, rdata3, rr[1]);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) begin
      a = $urandom;
      if ((a >> (AW + 2)) == 0) a = a | 32'h0010_0000;
    end else begin
      a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    end
    return a;
  endfunction

  function automatic logic [3:0] rand_wen();
    return ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w0;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) rm[d][w] = '0;
      rr[d] = '0;
      re[d] = 1'b0;
    end

    #23;
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata3", rdata3, 32'h0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_err3", 32'(err3), 32'd0);
    check("rst_stall3", 32'(stall3), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 16; w++) begin
      acc0(1'b1, 4'hF, 32'(w * 4), $urandom, "init0");
      acc3(4'hF, 32'(w * 4), $urandom, "init3");
    end

    acc0(1'b1, 4'hF, 32'h10, 32'h1122_3344, "tp_wr");
    acc0(1'b1, 4'h0, 32'h10, 32'h0, "tp_rd");
    check("tp_full", rdata0, 32'h1122_3344);
    acc0(1'b1, 4'b0100, 32'h10, 32'hAABB_CCDD, "tp_lane2");
    acc0(1'b1, 4'h0, 32'h10, 32'h0, "tp_rd2");
    check("tp_lane2_val", rdata0, 32'h11BB_3344);
    acc0(1'b1, 4'b0011, 32'h10, 32'h0000_EEFF, "tp_lane01");
    acc0(1'b1, 4'h0, 32'h12, 32'h0, "tp_rd3");
    check("tp_lane01_val", rdata0, 32'h11BB_EEFF);
    for (int i = 0; i < 3; i++) begin
      acc0(1'b0, 4'hF, 32'h10, 32'hFFFF_FFFF, "tp_idle");
      check("tp_idle_hold", rdata0, 32'h11BB_EEFF);
    end
    acc0(1'b1, 4'hF, 32'h20, 32'h0BAD_F00D, "tp_wr_else");
    check("tp_wr_hold", rdata0, 32'h11BB_EEFF);

    w0 = rm[0][0];
    acc0(1'b1, 4'h0, 32'h0000_1000, 32'h0, "tp_oor_rd");
    check("tp_oor_data", rdata0, ERRD);
    check("tp_oor_err", 32'(err0), 32'd1);
    acc0(1'b0, 4'h0, 32'h0, 32'h0, "tp_oor_idle");
    check("tp_oor_pulse", 32'(err0), 32'd0);
    acc0(1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, "tp_oor_wr");
    check("tp_oor_wr_err", 32'(err0), 32'd1);
    acc0(1'b1, 4'h0, 32'h0, 32'h0, "tp_word0");
    check("tp_word0_val", rdata0, w0);

    for (int i = 0; i < 300; i++) begin
      acc0(1'($urandom_range(0, 3) != 0), rand_wen(), rand_addr(), $urandom, "rnd0");
    end

    acc3(4'h0, 32'h10, 32'h0, "w3_rd");
    for (int i = 0; i < 40; i++) begin
      acc3(rand_wen(), rand_addr(), $urandom, "rnd3");
    end

    acc3(4'hF, 32'h14, 32'h5555_AAAA, "w3_pre_wr");
    acc3(4'h0, 32'h14, 32'h0, "w3_pre_rd");
    check("w3_pre_val", rdata3, 32'h5555_AAAA);
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h14; wdata3 = 32'h1234_5678;
    @(negedge clk);
    check("rb_stall_first", 32'(stall3), 32'd1);
    @(posedge clk); #1;
    check("rb_stall_second", 32'(stall3), 32'd1);
    rst = 1'b0;
    en3 = 1'b0;
    #1;
    check("rb_stall_drop", 32'(stall3), 32'd0);
    check("rb_rdata3", rdata3, 32'h0);
    check("rb_rdata0", rdata0, 32'h0);
    check("rb_err3", 32'(err3), 32'd0);
    @(posedge clk); #1;
    check("rb_stall_held", 32'(stall3), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rr[0] = '0;
    rr[1] = '0;
    @(posedge clk); #1;
    acc3(4'h0, 32'h14, 32'h0, "rb_after_rd");
    check("rb_old_data", rdata3, 32'h5555_AAAA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the data SRAM interface that the MEM stage reads through (en / byte-wen / addr / wdata / rdata).
- Models the data RAM behind the CPU: byte-lane writes, registered read data, optional wait states signalled as a stall request, and an out-of-range error flag.
- Sits beside the pipeline; EX drives the request, and MEM samples data_sram_rdata in the cycle after the access edge.

Parameters:
- ADDR_WIDTH, 10, word-index bits; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0, extra stall cycles per access (0..15).
- ERR_DATA, 32'h0, rdata value returned for an out-of-range read.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- data_sram_en  in  1  access request.
- data_sram_wen  in  4  byte write strobes; 4'b0000 = read, any nonzero value = write.
- data_sram_addr  in  32  byte address; [1:0] ignored, word index = addr[ADDR_WIDTH+1:2].
- data_sram_wdata  in  32  store data; lane i = bits [8i+7:8i].
- data_sram_rdata  out  32  registered read data.
- stallreq_mem  out  1  combinational stall request to the stall controller.
- addr_err  out  1  registered one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, data_sram_rdata=0, addr_err=0, latched request cleared. RAM contents are not reset.
- Range check: out-of-range when addr[31:ADDR_WIDTH+2] != 0.
- Access at an edge:
  - Write: each lane with wen[i]=1 updates the addressed word; other lanes are untouched; rdata holds.
  - Read: rdata <= mem[index] and is visible in the next cycle.
  - Out-of-range write: dropped.
  - Out-of-range read: rdata <= ERR_DATA.
  - addr_err <= 1 for any out-of-range access, 0 on every other edge.
- rdata holds its value across idle cycles (en=0) and across writes.
- WAIT_CYCLES=0:
  - A request in IDLE is serviced at the same edge.
  - stallreq_mem is constantly 0.
  - Back-to-back accesses every cycle are legal.
  - Write-then-read of the same word on consecutive edges returns the new data.
- WAIT_CYCLES=N>0 (FSM IDLE/BUSY):
  - IDLE with en=1: stallreq_mem=1 combinationally. At the edge, latch {wen, addr, wdata}, cnt <= N-1, go to BUSY.
  - BUSY: stallreq_mem = (cnt != 0). Inputs are ignored because the CPU holds them while stalled.
  - BUSY at an edge with cnt != 0: cnt decrements.
  - BUSY at an edge with cnt == 0: perform the latched access and go to IDLE.
  - Total stall = N cycles. Read data is valid in the first cycle after the stall releases, matching the MEM sampling point.
  - IDLE with en=0: no state change, stallreq_mem=0.
- Write with wen=4'b0000 and en=1 is a read by definition; en=0 ignores wen.
- Reset asserted mid-BUSY: the pending access is abandoned with no RAM write, the FSM returns to IDLE, and stallreq_mem drops immediately.

Test Plan:
- WAIT=0: write addr 0x10, wen 1111, wdata 0x11223344; then read 0x10 -> rdata=0x11223344 in the cycle after the read edge.
- Byte lanes: write 0x10 wen 0100 wdata 0xAABBCCDD; read -> 0x11BB3344. Then write wen 0011 wdata 0x0000EEFF; read -> 0x11BBEEFF.
- Hold: read 0x10, then 3 cycles en=0, then a write elsewhere -> rdata stays 0x11BBEEFF throughout.
- Out-of-range (ADDR_WIDTH=10): read 0x00001000 -> rdata=ERR_DATA and addr_err high exactly one cycle. Write to 0x00001000 leaves word 0 unchanged.
- WAIT=3: read request held -> stallreq_mem high for exactly 3 cycles, then low, and rdata is valid the next cycle. A write is committed only at the release edge.
- Reset mid-BUSY (WAIT=3): write issued, rst=0 during the 2nd stall cycle -> stallreq_mem=0 and rdata=0 immediately; a later read of that word shows old contents.
